// File: rtl/instr_encoder_loader.sv
// Packs RV32I instruction fields into 32-bit words and streams them into
// instruction memory through a registered, sequential write port.
module instr_encoder_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  finish,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            fmt,
   input  logic [6:0]            opcode,
   input  logic [4:0]            rd,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic [31:0]           imm,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);

   function automatic logic [31:0] encode(
      input logic [2:0]  f,
      input logic [6:0]  op,
      input logic [4:0]  d,
      input logic [4:0]  s1,
      input logic [4:0]  s2,
      input logic [2:0]  f3,
      input logic [6:0]  f7,
      input logic [31:0] im
   );
      logic [31:0] w;
      case (f)
         3'd0:    w = {f7, s2, s1, f3, d, op};
         3'd1:    w = {im[11:0], s1, f3, d, op};
         3'd2:    w = {im[11:5], s2, s1, f3, im[4:0], op};
         3'd3:    w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
         3'd4:    w = {im[31:12], d, op};
         3'd5:    w = {im[20], im[10:1], im[11], im[19:12], d, op};
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   state_t                state_r, state_s;
   logic [ADDR_WIDTH-1:0] ptr_r, ptr_s;
   logic [ADDR_WIDTH:0]   count_s;
   logic                  full_s, err_s, wr_s, xfer_s, legal_s;
   logic [31:0]           enc_s;

   assign xfer_s  = in_valid && in_ready;
   assign legal_s = (fmt <= 3'd5);
   assign enc_s   = encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);

   // Next-state logic: start always wins over finish.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_s = LOAD;
            else       state_s = IDLE;
         end
         LOAD: begin
            if (start)       state_s = LOAD;
            else if (finish) state_s = DONE;
            else             state_s = LOAD;
         end
         DONE: begin
            if (start) state_s = LOAD;
            else       state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // Pointer, count and error bookkeeping; illegal formats complete the handshake without writing.
   always_comb begin
      ptr_s   = ptr_r;
      count_s = count;
      err_s   = err;
      wr_s    = 1'b0;
      if (start) begin
         ptr_s   = BASE_C;
         count_s = '0;
         err_s   = 1'b0;
      end else if (xfer_s && legal_s) begin
         wr_s    = 1'b1;
         ptr_s   = ptr_r + ADDR_WIDTH'(1);
         count_s = count + (ADDR_WIDTH+1)'(1);
      end else if (xfer_s) begin
         err_s   = 1'b1;
      end else begin
         wr_s    = 1'b0;
      end
      full_s = (count_s == DEPTH_C);
   end

   // State, bookkeeping and registered write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         ptr_r     <= BASE_C;
         count     <= '0;
         full      <= 1'b0;
         err       <= 1'b0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_C;
         mem_wdata <= 32'd0;
      end else begin
         state_r  <= state_s;
         ptr_r    <= ptr_s;
         count    <= count_s;
         full     <= full_s;
         err      <= err_s;
         in_ready <= (state_s == LOAD) && !full_s;
         mem_we   <= wr_s;
         if (wr_s) begin
            mem_addr  <= ptr_r;
            mem_wdata <= enc_s;
         end else begin
            mem_addr  <= mem_addr;
            mem_wdata <= mem_wdata;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench with scoreboards: one default-size loader and one 4-word loader.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst, start, start2, finish, in_valid;
   logic [2:0]  fmt, funct3;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm;

   logic        rdy0, we0, full0, err0;
   logic [7:0]  addr0;
   logic [31:0] wd0;
   logic [8:0]  cnt0;

   logic        rdy1, we1, full1, err1;
   logic [1:0]  addr1;
   logic [31:0] wd1;
   logic [2:0]  cnt1;

   int total = 0;
   int bad   = 0;
   logic [39:0] q0[$];
   logic [39:0] q1[$];
   logic [39:0] e0, e1;

   always #5 clk = ~clk;

   instr_encoder_loader dut0 (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(rdy0), .fmt(fmt), .opcode(opcode),
      .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
      .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0), .count(cnt0),
      .full(full0), .err(err0));

   instr_encoder_loader #(.ADDR_WIDTH(2)) dut1 (
      .clk(clk), .rst(rst), .start(start2), .finish(finish),
      .in_valid(in_valid), .in_ready(rdy1), .fmt(fmt), .opcode(opcode),
      .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
      .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1), .count(cnt1),
      .full(full1), .err(err1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
      in_valid = 1'b1; fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
      funct3 = f3; funct7 = f7; imm = im;
      cyc();
   endtask

   function automatic logic [31:0] addi_x1(input int k);
      return 32'h00000093 | (32'(k) << 20);
   endfunction

   // Scoreboard for the default-size loader.
   always @(negedge clk) begin
      if (we0 === 1'b1) begin
         if (q0.size() == 0) chk("we0_unexpected", 64'd1, 64'd0);
         else begin
            e0 = q0.pop_front();
            chk("addr0", 64'(addr0), 64'(e0[39:32]));
            chk("data0", 64'(wd0), 64'(e0[31:0]));
         end
      end
   end

   // Scoreboard for the 4-word loader.
   always @(negedge clk) begin
      if (we1 === 1'b1) begin
         if (q1.size() == 0) chk("we1_unexpected", 64'd1, 64'd0);
         else begin
            e1 = q1.pop_front();
            chk("addr1", 64'(addr1), 64'(e1[39:32]));
            chk("data1", 64'(wd1), 64'(e1[31:0]));
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; start2 = 1'b0; finish = 1'b0; in_valid = 1'b0;
      fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
      cyc(); cyc();
      chk("rst_ready", 64'(rdy0), 64'd0);
      chk("rst_we",    64'(we0),  64'd0);
      chk("rst_full",  64'(full0), 64'd0);
      chk("rst_err",   64'(err0), 64'd0);
      chk("rst_addr",  64'(addr0), 64'd0);
      chk("rst_wdata", 64'(wd0),  64'd0);
      chk("rst_count", 64'(cnt0), 64'd0);
      rst = 1'b0;

      // R-type after start
      start = 1'b1; cyc(); start = 1'b0;
      chk("load_ready", 64'(rdy0), 64'd1);
      q0.push_back({8'd0, 32'h01CE0333});
      send(3'd0, 7'h33, 5'd6, 5'd28, 5'd28, 3'd0, 7'd0, 32'd0);
      in_valid = 1'b0;
      chk("r_we",    64'(we0),  64'd1);
      chk("r_count", 64'(cnt0), 64'd1);
      cyc();

      // Back-to-back I, S, B, U, J
      start = 1'b1; cyc(); start = 1'b0;
      q0.push_back({8'd0, 32'h00500093});
      q0.push_back({8'd1, 32'h00512423});
      q0.push_back({8'd2, 32'hFE000EE3});
      q0.push_back({8'd3, 32'h123452B7});
      q0.push_back({8'd4, 32'h0000006F});
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      send(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8);
      send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
      send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
      send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      in_valid = 1'b0;
      chk("b2b_count", 64'(cnt0), 64'd5);
      cyc();
      chk("b2b_drained", 64'(q0.size()), 64'd0);
      finish = 1'b1; cyc(); finish = 1'b0;

      // 4-word loader fills after four accepts
      start2 = 1'b1; cyc(); start2 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         q1.push_back({6'd0, 2'(k - 1), addi_x1(k)});
         send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
      end
      chk("full_flag",  64'(full1), 64'd1);
      chk("full_ready", 64'(rdy1),  64'd0);
      chk("full_count", 64'(cnt1),  64'd4);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
      in_valid = 1'b0;
      cyc();
      chk("full_drained", 64'(q1.size()), 64'd0);
      chk("full_count2",  64'(cnt1),      64'd4);
      finish = 1'b1; cyc(); finish = 1'b0;

      // Illegal format between two legal bundles
      start = 1'b1; cyc(); start = 1'b0;
      q0.push_back({8'd0, addi_x1(7)});
      q0.push_back({8'd1, 32'h123452B7});
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
      send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
      in_valid = 1'b0;
      cyc();
      chk("ill_err",     64'(err0),      64'd1);
      chk("ill_count",   64'(cnt0),      64'd2);
      chk("ill_drained", 64'(q0.size()), 64'd0);
      start = 1'b1; cyc(); start = 1'b0;
      chk("clr_err",   64'(err0), 64'd0);
      chk("clr_count", 64'(cnt0), 64'd0);

      // finish coincident with a transfer
      q0.push_back({8'd0, addi_x1(9)});
      finish = 1'b1;
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
      finish = 1'b0;
      chk("fin_we",    64'(we0),  64'd1);
      chk("fin_ready", 64'(rdy0), 64'd0);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
      in_valid = 1'b0;
      cyc();
      chk("fin_count", 64'(cnt0), 64'd1);
      start = 1'b1; cyc(); start = 1'b0;
      q0.push_back({8'd0, addi_x1(10)});
      q0.push_back({8'd1, addi_x1(11)});
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd11);
      in_valid = 1'b0;

      // Reset the cycle after a transfer
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("rst2_we",    64'(we0),   64'd0);
      chk("rst2_ready", 64'(rdy0),  64'd0);
      chk("rst2_addr",  64'(addr0), 64'd0);
      chk("rst2_wdata", 64'(wd0),   64'd0);
      chk("rst2_count", 64'(cnt0),  64'd0);
      chk("rst2_full",  64'(full1), 64'd0);
      cyc();
      chk("rst2_drained", 64'(q0.size()), 64'd0);
      chk("rst2_we_after", 64'(we0), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
